// File: rtl/pipe_tx_scrambler.sv
// Per-lane Gen1/Gen2 (8b/10b) transmit scrambler. One register stage for all outputs.
// D symbols are XORed with the PCIe 16-bit Galois LFSR (x^16+x^5+x^4+x^3+1).
// COM reloads the LFSR, SKP holds it, and Gen3+ rates pass data through unchanged.
// curr_data_rate_i encoding: 0=gen1, 1=gen2, 2=gen3, 3=gen4, 4=gen5.
// Optional macro PIPE_TX_SCRAMBLER_BYPASS_EN adds scramble_disable_i. When a lane's bit is
// high, that lane's D symbols go out unscrambled, but the LFSR still follows its normal rules.
module pipe_tx_scrambler #(
  parameter int unsigned MAX_NUM_LANES = 4,
  parameter int unsigned DATA_WIDTH    = 32
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [2:0]                      curr_data_rate_i,
  input  logic [5:0]                      pipe_width_i,
  input  logic                            tx_training_i,
`ifdef PIPE_TX_SCRAMBLER_BYPASS_EN
  input  logic [MAX_NUM_LANES-1:0]        scramble_disable_i,
`endif
  input  logic [MAX_NUM_LANES*32-1:0]     data_in_i,
  input  logic [MAX_NUM_LANES-1:0]        data_valid_i,
  input  logic [MAX_NUM_LANES*4-1:0]      d_k_in_i,
  input  logic [MAX_NUM_LANES*2-1:0]      sync_header_i,
  output logic [MAX_NUM_LANES*32-1:0]     data_out_o,
  output logic [MAX_NUM_LANES-1:0]        data_valid_o,
  output logic [MAX_NUM_LANES*4-1:0]      d_k_out_o,
  output logic [MAX_NUM_LANES*2-1:0]      sync_header_o
);

  localparam int unsigned NumBytes = DATA_WIDTH / 8;
  localparam logic [2:0]  RateGen3 = 3'd2;
  localparam logic [7:0]  SymCom   = 8'hBC;
  localparam logic [7:0]  SymSkp   = 8'h1C;

  // Eight Galois shifts; bit 15 feeds back into bits 0, 3, 4 and 5.
  function automatic logic [15:0] lfsr_adv8(input logic [15:0] s);
    logic [15:0] n;
    n = s;
    for (int i = 0; i < 8; i++) begin
      n = {n[14:0], n[15]} ^ {10'b0, n[15], n[15], n[15], 3'b0};
    end
    return n;
  endfunction

  // Scramble byte bit i comes from LFSR bit 15-i.
  function automatic logic [7:0] scr_byte(input logic [15:0] s);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) begin
      b[i] = s[15-i];
    end
    return b;
  endfunction

  logic [MAX_NUM_LANES-1:0][15:0] lfsr_q, lfsr_d;
  logic [MAX_NUM_LANES*32-1:0]    data_d;
  logic [MAX_NUM_LANES-1:0]       valid_d;
  logic [MAX_NUM_LANES*4-1:0]     dk_d;
  logic [MAX_NUM_LANES*2-1:0]     sync_d;
  logic [MAX_NUM_LANES-1:0]       scr_dis;
  logic [2:0]                     num_bytes;
  logic                           rate_8b10b;
  logic [15:0]                    lfsr;
  logic [7:0]                     sym;
  logic                           is_k;

`ifdef PIPE_TX_SCRAMBLER_BYPASS_EN
  assign scr_dis = scramble_disable_i;
`else
  assign scr_dis = '0;
`endif

  assign rate_8b10b = (curr_data_rate_i < RateGen3);

  // Active byte count per word. Unsupported widths fall back to one byte.
  always_comb begin
    num_bytes = 3'd1;
    case (pipe_width_i)
      6'd16:   num_bytes = 3'd2;
      6'd32:   num_bytes = 3'd4;
      default: num_bytes = 3'd1;
    endcase
  end

  // Per-lane scrambling. The LFSR chains combinationally through the active bytes.
  always_comb begin
    data_d  = data_out_o;
    dk_d    = d_k_out_o;
    sync_d  = sync_header_o;
    valid_d = '0;
    lfsr_d  = lfsr_q;
    lfsr    = 16'hFFFF;
    sym     = 8'h00;
    is_k    = 1'b0;
    for (int l = 0; l < MAX_NUM_LANES; l++) begin
      if (data_valid_i[l]) begin
        valid_d[l]          = 1'b1;
        data_d[l*32 +: 32]  = data_in_i[l*32 +: 32];
        dk_d[l*4 +: 4]      = d_k_in_i[l*4 +: 4];
        sync_d[l*2 +: 2]    = sync_header_i[l*2 +: 2];
        if (!rate_8b10b) begin
          lfsr_d[l] = 16'hFFFF;
        end else begin
          lfsr = lfsr_q[l];
          for (int b = 0; b < NumBytes; b++) begin
            if (3'(b) < num_bytes) begin
              sym  = data_in_i[l*32 + b*8 +: 8];
              is_k = d_k_in_i[l*4 + b];
              if (is_k && sym == SymCom) begin
                lfsr = lfsr_adv8(16'hFFFF);
              end else if (is_k && sym == SymSkp) begin
                lfsr = lfsr;
              end else if (is_k) begin
                lfsr = lfsr_adv8(lfsr);
              end else begin
                if (!tx_training_i && !scr_dis[l]) begin
                  data_d[l*32 + b*8 +: 8] = sym ^ scr_byte(lfsr);
                end
                lfsr = lfsr_adv8(lfsr);
              end
            end
          end
          lfsr_d[l] = lfsr;
        end
      end
    end
  end

  // Output and LFSR state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lfsr_q        <= '1;
      data_out_o    <= '0;
      data_valid_o  <= '0;
      d_k_out_o     <= '0;
      sync_header_o <= '0;
    end else begin
      lfsr_q        <= lfsr_d;
      data_out_o    <= data_d;
      data_valid_o  <= valid_d;
      d_k_out_o     <= dk_d;
      sync_header_o <= sync_d;
    end
  end

endmodule

// File: tb/tb_pipe_tx_scrambler.sv
// Table-driven bench for pipe_tx_scrambler with hand-computed PCIe scramble bytes.
module tb_pipe_tx_scrambler;

  localparam int unsigned L = 4;
  localparam logic [2:0] Gen1 = 3'd0;
  localparam logic [2:0] Gen2 = 3'd1;
  localparam logic [2:0] Gen3 = 3'd2;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b1;
  logic [2:0]      curr_data_rate_i = Gen1;
  logic [5:0]      pipe_width_i = 6'd8;
  logic            tx_training_i = 1'b0;
  logic [L*32-1:0] data_in_i = '0;
  logic [L-1:0]    data_valid_i = '0;
  logic [L*4-1:0]  d_k_in_i = '0;
  logic [L*2-1:0]  sync_header_i = '0;
  logic [L*32-1:0] data_out_o;
  logic [L-1:0]    data_valid_o;
  logic [L*4-1:0]  d_k_out_o;
  logic [L*2-1:0]  sync_header_o;
`ifdef PIPE_TX_SCRAMBLER_BYPASS_EN
  logic [L-1:0]    scramble_disable_i = '0;
`endif

  pipe_tx_scrambler #(.MAX_NUM_LANES(L), .DATA_WIDTH(32)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .curr_data_rate_i (curr_data_rate_i),
    .pipe_width_i     (pipe_width_i),
    .tx_training_i    (tx_training_i),
`ifdef PIPE_TX_SCRAMBLER_BYPASS_EN
    .scramble_disable_i (scramble_disable_i),
`endif
    .data_in_i        (data_in_i),
    .data_valid_i     (data_valid_i),
    .d_k_in_i         (d_k_in_i),
    .sync_header_i    (sync_header_i),
    .data_out_o       (data_out_o),
    .data_valid_o     (data_valid_o),
    .d_k_out_o        (d_k_out_o),
    .sync_header_o    (sync_header_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string       name;
    logic [2:0]  rate;
    logic [5:0]  width;
    logic        trn;
    logic        vld;
    logic [31:0] data;
    logic [3:0]  dk;
    logic [1:0]  sync;
    logic        ev;
    logic [31:0] ed;
    logic [3:0]  edk;
    logic [1:0]  esync;
  } vec_t;

  vec_t        vecs[$];
  int          checks = 0;
  int          errors = 0;
  logic [3:0]  held_dk = '0;
  logic [1:0]  held_sync = '0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Expected K flags and sync header follow the input when valid, otherwise hold.
  task automatic add(input string name, input logic [2:0] rate, input logic [5:0] width,
                     input logic trn, input logic vld, input logic [31:0] data,
                     input logic [3:0] dk, input logic [1:0] sync, input logic [31:0] ed);
    vec_t v;
    v.name = name; v.rate = rate; v.width = width; v.trn = trn; v.vld = vld;
    v.data = data; v.dk = dk; v.sync = sync; v.ev = vld; v.ed = ed;
    if (vld) begin
      held_dk = dk;
      held_sync = sync;
    end
    v.edk = held_dk;
    v.esync = held_sync;
    vecs.push_back(v);
  endtask

  task automatic drive_lane0(input logic vld, input logic [31:0] data, input logic [3:0] dk,
                             input logic [1:0] sync);
    data_in_i     = '0;
    d_k_in_i      = '0;
    sync_header_i = '0;
    data_valid_i  = '0;
    data_in_i[31:0]    = data;
    d_k_in_i[3:0]      = dk;
    sync_header_i[1:0] = sync;
    data_valid_i[0]    = vld;
  endtask

  initial begin
    // Gen1 width 8: COM then data 00 follows FF,17,C0,14 scramble sequence.
    add("g1_com",    Gen1, 6'd8,  1'b0, 1'b1, 32'h000000BC, 4'b0001, 2'b00, 32'h000000BC);
    add("g1_d1",     Gen1, 6'd8,  1'b0, 1'b1, 32'h00000000, 4'b0000, 2'b00, 32'h00000017);
    add("g1_d2",     Gen1, 6'd8,  1'b0, 1'b1, 32'h00000000, 4'b0000, 2'b11, 32'h000000C0);
    add("g1_d3",     Gen1, 6'd8,  1'b0, 1'b1, 32'h00000000, 4'b0000, 2'b00, 32'h00000014);
    // Gen2 width 32 chaining within a word.
    add("g2_com_w",  Gen2, 6'd32, 1'b0, 1'b1, 32'h000000BC, 4'b0001, 2'b00, 32'h14C017BC);
    add("g2_d_w",    Gen2, 6'd32, 1'b0, 1'b1, 32'h00000000, 4'b0000, 2'b00, 32'h8202E7B2);
    // SKP holds the LFSR.
    add("skp_com",   Gen1, 6'd8,  1'b0, 1'b1, 32'h000000BC, 4'b0001, 2'b00, 32'h000000BC);
    add("skp_d1",    Gen1, 6'd8,  1'b0, 1'b1, 32'h00000000, 4'b0000, 2'b00, 32'h00000017);
    add("skp_1",     Gen1, 6'd8,  1'b0, 1'b1, 32'h0000001C, 4'b0001, 2'b00, 32'h0000001C);
    add("skp_2",     Gen1, 6'd8,  1'b0, 1'b1, 32'h0000001C, 4'b0001, 2'b00, 32'h0000001C);
    add("skp_3",     Gen1, 6'd8,  1'b0, 1'b1, 32'h0000001C, 4'b0001, 2'b00, 32'h0000001C);
    add("skp_d2",    Gen1, 6'd8,  1'b0, 1'b1, 32'h00000000, 4'b0000, 2'b00, 32'h000000C0);
    // Valid gap: outputs hold, LFSR holds.
    add("gap_com",   Gen1, 6'd8,  1'b0, 1'b1, 32'h000000BC, 4'b0001, 2'b00, 32'h000000BC);
    add("gap_d1",    Gen1, 6'd8,  1'b0, 1'b1, 32'h00000000, 4'b0000, 2'b10, 32'h00000017);
    add("gap_idle1", Gen1, 6'd8,  1'b0, 1'b0, 32'hFFFFFFFF, 4'b1111, 2'b01, 32'h00000017);
    add("gap_idle2", Gen1, 6'd8,  1'b0, 1'b0, 32'hFFFFFFFF, 4'b1111, 2'b01, 32'h00000017);
    add("gap_idle3", Gen1, 6'd8,  1'b0, 1'b0, 32'hFFFFFFFF, 4'b1111, 2'b01, 32'h00000017);
    add("gap_d2",    Gen1, 6'd8,  1'b0, 1'b1, 32'h00000000, 4'b0000, 2'b00, 32'h000000C0);
    add("gap_d3",    Gen1, 6'd8,  1'b0, 1'b1, 32'h00000000, 4'b0000, 2'b00, 32'h00000014);
    // Training: D unscrambled but LFSR advances.
    add("trn_com",   Gen1, 6'd8,  1'b1, 1'b1, 32'h000000BC, 4'b0001, 2'b00, 32'h000000BC);
    add("trn_d1",    Gen1, 6'd8,  1'b1, 1'b1, 32'h00000000, 4'b0000, 2'b00, 32'h00000000);
    add("trn_d2",    Gen1, 6'd8,  1'b1, 1'b1, 32'h00000000, 4'b0000, 2'b00, 32'h00000000);
    add("trn_off",   Gen1, 6'd8,  1'b0, 1'b1, 32'h00000000, 4'b0000, 2'b00, 32'h00000014);
    // Non-COM/SKP K symbol passes and advances.
    add("k_com",     Gen1, 6'd8,  1'b0, 1'b1, 32'h000000BC, 4'b0001, 2'b00, 32'h000000BC);
    add("k_fc",      Gen1, 6'd8,  1'b0, 1'b1, 32'h000000FC, 4'b0001, 2'b00, 32'h000000FC);
    add("k_d",       Gen1, 6'd8,  1'b0, 1'b1, 32'h00000000, 4'b0000, 2'b00, 32'h000000C0);
    // Width 16: upper bytes pass and do not advance.
    add("w16_com",   Gen1, 6'd16, 1'b0, 1'b1, 32'hAA5500BC, 4'b0001, 2'b00, 32'hAA5517BC);
    add("w16_d",     Gen1, 6'd16, 1'b0, 1'b1, 32'h00000000, 4'b0000, 2'b00, 32'h000014C0);
    // Unsupported width acts as 8.
    add("w24_com",   Gen1, 6'd24, 1'b0, 1'b1, 32'h000000BC, 4'b0001, 2'b00, 32'h000000BC);
    add("w24_d",     Gen1, 6'd24, 1'b0, 1'b1, 32'h11223300, 4'b0000, 2'b00, 32'h11223317);
    // Gen3 pass-through, then LFSR is back at FFFF.
    add("g3_a",      Gen3, 6'd16, 1'b0, 1'b1, 32'h12345678, 4'b0101, 2'b01, 32'h12345678);
    add("g3_b",      Gen3, 6'd32, 1'b0, 1'b1, 32'h9ABCDEF0, 4'b0000, 2'b10, 32'h9ABCDEF0);
    add("post_g3_1", Gen1, 6'd8,  1'b0, 1'b1, 32'h00000000, 4'b0000, 2'b00, 32'h000000FF);
    add("post_g3_2", Gen1, 6'd8,  1'b0, 1'b1, 32'h00000000, 4'b0000, 2'b00, 32'h00000017);

    // Reset state.
    #2;
    check("rst_data", data_out_o, '0);
    check("rst_ctl", {data_valid_o, d_k_out_o, sync_header_o}, '0);
    tick();
    rst_i = 1'b0;

    foreach (vecs[i]) begin
      curr_data_rate_i = vecs[i].rate;
      pipe_width_i     = vecs[i].width;
      tx_training_i    = vecs[i].trn;
      drive_lane0(vecs[i].vld, vecs[i].data, vecs[i].dk, vecs[i].sync);
      tick();
      check({vecs[i].name, "_data"}, 128'(data_out_o), {96'b0, vecs[i].ed});
      check({vecs[i].name, "_ctl"}, 128'({data_valid_o, d_k_out_o, sync_header_o}),
            128'({4'b0, vecs[i].ev, 12'b0, vecs[i].edk, 6'b0, vecs[i].esync}));
    end

    // Asynchronous reset mid-stream clears outputs without a clock edge.
    curr_data_rate_i = Gen1;
    pipe_width_i     = 6'd8;
    tx_training_i    = 1'b0;
    drive_lane0(1'b1, 32'h000000BC, 4'b0001, 2'b11);
    tick();
    drive_lane0(1'b1, 32'h00000000, 4'b0000, 2'b11);
    tick();
    check("pre_rst_d", 128'(data_out_o), 128'h17);
    rst_i = 1'b1;
    #1;
    check("async_rst_data", data_out_o, '0);
    check("async_rst_ctl", {data_valid_o, d_k_out_o, sync_header_o}, '0);
    tick();
    drive_lane0(1'b0, 32'h0, 4'b0, 2'b0);
    rst_i = 1'b0;

    // Lane independence: lane 2 runs a COM sequence while lane 0 idles.
    data_in_i[95:64] = 32'h000000BC;
    d_k_in_i[11:8]   = 4'b0001;
    data_valid_i[2]  = 1'b1;
    tick();
    check("lane2_com", 128'(data_out_o[95:64]), 128'hBC);
    check("lane2_vld", 128'(data_valid_o), 128'b0100);
    data_in_i[95:64] = 32'h0;
    d_k_in_i[11:8]   = 4'b0000;
    tick();
    check("lane2_d1", 128'(data_out_o[95:64]), 128'h17);
    check("lane0_idle", 128'(data_out_o[31:0]), 128'h0);

    // Lane 0 after reset, no COM: first D XOR FF.
    drive_lane0(1'b1, 32'h00000000, 4'b0000, 2'b00);
    tick();
    check("post_rst_ff", 128'(data_out_o[31:0]), 128'hFF);
    check("post_rst_vld", 128'(data_valid_o), 128'b0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
